// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer arbiter: source indices, FSM states and
// per-source tone pattern descriptors.
package buzzer_pkg;

    localparam logic [1:0] SRC_KEY   = 2'd0;
    localparam logic [1:0] SRC_PASS  = 2'd1;
    localparam logic [1:0] SRC_FAIL  = 2'd2;
    localparam logic [1:0] SRC_ALARM = 2'd3;
    localparam int         NUM_SRC   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        SIL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] half;
        logic [31:0] on;
        logic [31:0] off;
        logic [31:0] rep;
    } pattern_t;

    function automatic pattern_t get_pattern(
        input logic [1:0] src,
        input pattern_t   key_pat,
        input pattern_t   pass_pat,
        input pattern_t   fail_pat,
        input pattern_t   alarm_pat
    );
        case (src)
            SRC_KEY:  return key_pat;
            SRC_PASS: return pass_pat;
            SRC_FAIL: return fail_pat;
            default:  return alarm_pat;
        endcase
    endfunction

    // Zero-length segments or half-periods would make the >= (param-1) compares wrap.
    function automatic bit pattern_legal(input pattern_t pat);
        return (pat.half >= 32'd1) && (pat.on >= 32'd1) && (pat.off >= 32'd1);
    endfunction

endpackage

// File: rtl/buzzer_arbiter_tone_toggler.sv
// Square-wave generator: restart forces the output high with a fresh phase,
// enable keeps it toggling every HALF cycles, otherwise it idles low.
module tone_toggler #(
    parameter logic [31:0] HALF = 32'd1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic tone
);

    logic [31:0] cnt_reg;
    logic        tone_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= 32'd0;
            tone_reg <= 1'b0;
        end else if (restart) begin
            cnt_reg  <= 32'd0;
            tone_reg <= 1'b1;
        end else if (enable) begin
            if (cnt_reg >= HALF - 32'd1) begin
                cnt_reg  <= 32'd0;
                tone_reg <= ~tone_reg;
            end else begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end else begin
            cnt_reg  <= 32'd0;
            tone_reg <= 1'b0;
        end
    end

    assign tone = tone_reg;

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority, preemptive arbiter sharing one piezo between key click,
// PASS chime, FAIL double-beep and the lockout alarm.
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int unsigned KEY_HALF   = 50000,
    parameter int unsigned KEY_ON     = 10000000,
    parameter int unsigned PASS_HALF  = 25000,
    parameter int unsigned PASS_ON    = 30000000,
    parameter int unsigned FAIL_HALF  = 100000,
    parameter int unsigned FAIL_ON    = 5000000,
    parameter int unsigned FAIL_OFF   = 5000000,
    parameter int unsigned FAIL_REP   = 2,
    parameter int unsigned ALARM_HALF = 50000,
    parameter int unsigned ALARM_ON   = 25000000,
    parameter int unsigned ALARM_OFF  = 25000000,
    parameter int unsigned GAP        = 2500000
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       key_req,
    input  logic       pass_req,
    input  logic       fail_req,
    input  logic       alarm_en,
    output logic       buzzer,
    output logic       busy,
    output logic [3:0] grant,
    output logic       done
);

    localparam pattern_t KEY_PAT   = '{half: 32'(KEY_HALF),   on: 32'(KEY_ON),
                                       off: 32'(GAP),         rep: 32'd1};
    localparam pattern_t PASS_PAT  = '{half: 32'(PASS_HALF),  on: 32'(PASS_ON),
                                       off: 32'(GAP),         rep: 32'd1};
    localparam pattern_t FAIL_PAT  = '{half: 32'(FAIL_HALF),  on: 32'(FAIL_ON),
                                       off: 32'(FAIL_OFF),    rep: 32'(FAIL_REP)};
    localparam pattern_t ALARM_PAT = '{half: 32'(ALARM_HALF), on: 32'(ALARM_ON),
                                       off: 32'(ALARM_OFF),   rep: 32'd0};

    if (!(pattern_legal(KEY_PAT) && pattern_legal(PASS_PAT) && pattern_legal(FAIL_PAT) &&
          pattern_legal(ALARM_PAT) && FAIL_REP >= 1 && FAIL_REP <= 15)) begin : g_param_check
        $error("buzzer_arbiter: HALF/ON/OFF/GAP must be >= 1 and FAIL_REP in 1..15");
    end

    state_t      state_reg, state_next;
    logic [1:0]  src_reg, src_next;
    logic [31:0] seg_reg, seg_next;
    logic [31:0] beep_reg, beep_next;
    logic [2:0]  pending_reg, pending_next;
    logic        done_reg, done_next;

    pattern_t    cur;
    logic [3:0]  req;
    logic        active;
    logic        seg_last;
    logic        more_beeps;
    logic        complete;
    logic        preempt;
    logic [1:0]  preempt_src;
    logic [2:0]  pend_merge;
    logic        pend_any;
    logic [1:0]  pend_src;
    logic        tone_start;

    always_comb begin
        cur      = get_pattern(src_reg, KEY_PAT, PASS_PAT, FAIL_PAT, ALARM_PAT);
        req      = {alarm_en, fail_req, pass_req, key_req};
        active   = (state_reg != IDLE);
        seg_last = (state_reg == TONE) ? (seg_reg >= cur.on - 32'd1)
                                       : (seg_reg >= cur.off - 32'd1);

        // Ascending scan so the highest qualifying source ends up selected.
        preempt     = 1'b0;
        preempt_src = SRC_KEY;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i] && (!active || 2'(i) > src_reg)) begin
                preempt     = 1'b1;
                preempt_src = 2'(i);
            end
        end

        // Pulse requests that do not start right now are remembered; alarm never is.
        pend_merge = pending_reg | (req[2:0] & ~(preempt ? (3'b001 << preempt_src) : 3'b000));
        pend_any   = |pend_merge;
        pend_src   = SRC_KEY;
        for (int i = 0; i < NUM_SRC - 1; i++) begin
            if (pend_merge[i]) begin
                pend_src = 2'(i);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        src_next     = src_reg;
        seg_next     = seg_reg;
        beep_next    = beep_reg;
        pending_next = pend_merge;
        done_next    = 1'b0;
        tone_start   = 1'b0;
        more_beeps   = 1'b0;
        complete     = 1'b0;

        case (state_reg)
            TONE: begin
                if (seg_last) begin
                    state_next = SIL;
                    seg_next   = 32'd0;
                end else begin
                    seg_next = seg_reg + 32'd1;
                end
            end
            SIL: begin
                if (seg_last) begin
                    beep_next  = beep_reg + 32'd1;
                    more_beeps = (src_reg == SRC_FAIL)  ? (beep_reg + 32'd1 < cur.rep) :
                                 (src_reg == SRC_ALARM) ? alarm_en : 1'b0;
                    if (more_beeps) begin
                        state_next = TONE;
                        seg_next   = 32'd0;
                        tone_start = 1'b1;
                    end else begin
                        complete = 1'b1;
                    end
                end else begin
                    seg_next = seg_reg + 32'd1;
                end
            end
            default: ;
        endcase

        if (preempt) begin
            // An aborted pattern is dropped, but a coincident natural end still reports done.
            state_next = TONE;
            src_next   = preempt_src;
            seg_next   = 32'd0;
            beep_next  = 32'd0;
            tone_start = 1'b1;
            done_next  = complete;
        end else if (complete) begin
            done_next = 1'b1;
            seg_next  = 32'd0;
            beep_next = 32'd0;
            if (pend_any) begin
                state_next   = TONE;
                src_next     = pend_src;
                tone_start   = 1'b1;
                pending_next = pend_merge & ~(3'b001 << pend_src);
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_reg   <= IDLE;
            src_reg     <= SRC_KEY;
            seg_reg     <= 32'd0;
            beep_reg    <= 32'd0;
            pending_reg <= 3'b000;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            src_reg     <= src_next;
            seg_reg     <= seg_next;
            beep_reg    <= beep_next;
            pending_reg <= pending_next;
            done_reg    <= done_next;
        end
    end

    logic [NUM_SRC-1:0] tone;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_tone
        localparam pattern_t PAT = get_pattern(2'(gi), KEY_PAT, PASS_PAT, FAIL_PAT, ALARM_PAT);

        tone_toggler #(
            .HALF(PAT.half)
        ) u_tone (
            .clk    (clk),
            .rst_n  (RSTn),
            .enable (state_next == TONE && src_next == 2'(gi)),
            .restart(tone_start && src_next == 2'(gi)),
            .tone   (tone[gi])
        );
    end

    assign buzzer = |tone;
    assign busy   = (state_reg != IDLE);
    assign grant  = busy ? (4'b0001 << src_reg) : 4'b0000;
    assign done   = done_reg;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter with small pattern parameters; each cycle
// compares {buzzer, busy, grant, done} against hand-derived tone tables.
module tb_buzzer_arbiter;

    logic       clk = 1'b0;
    logic       RSTn = 1'b0;
    logic       key_req = 1'b0;
    logic       pass_req = 1'b0;
    logic       fail_req = 1'b0;
    logic       alarm_en = 1'b0;
    logic       buzzer;
    logic       busy;
    logic [3:0] grant;
    logic       done;
    logic [6:0] obs;
    logic [6:0] exp_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign obs = {buzzer, busy, grant, done};

    buzzer_arbiter #(
        .KEY_HALF(2), .KEY_ON(8), .GAP(3),
        .PASS_HALF(1), .PASS_ON(6),
        .FAIL_HALF(3), .FAIL_ON(6), .FAIL_OFF(4), .FAIL_REP(2),
        .ALARM_HALF(2), .ALARM_ON(4), .ALARM_OFF(4)
    ) dut (
        .clk(clk), .RSTn(RSTn),
        .key_req(key_req), .pass_req(pass_req), .fail_req(fail_req), .alarm_en(alarm_en),
        .buzzer(buzzer), .busy(busy), .grant(grant), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {buzzer,busy,grant,done} at relative cycle n of each pattern (n=1 first TONE cycle).
    function automatic logic [6:0] exp_key(input int n);
        if (n <= 8)  return {(((n - 1) / 2) % 2 == 0), 1'b1, 4'b0001, 1'b0};
        if (n <= 11) return {1'b0, 1'b1, 4'b0001, 1'b0};
        return 7'b0000001;
    endfunction

    function automatic logic [6:0] exp_pass(input int n);
        if (n <= 6) return {((n - 1) % 2 == 0), 1'b1, 4'b0010, 1'b0};
        if (n <= 9) return {1'b0, 1'b1, 4'b0010, 1'b0};
        return 7'b0000001;
    endfunction

    function automatic logic [6:0] exp_fail(input int n);
        int ph;
        if (n > 20) return 7'b0000001;
        ph = (n - 1) % 10;
        return {(ph < 3), 1'b1, 4'b0100, 1'b0};
    endfunction

    function automatic logic [6:0] exp_alarm(input int n, input int beeps);
        int ph;
        if (n > 8 * beeps) return 7'b0000001;
        ph = (n - 1) % 8;
        return {(ph < 2), 1'b1, 4'b1000, 1'b0};
    endfunction

    task automatic test_reset();
        step();
        step();
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=%b", obs, 7'b0);
        end
        #3 RSTn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", c, obs, 7'b0);
            end
        end
        $display("reset: outputs idle after release");
    endtask

    task automatic test_key();
        key_req = 1'b1;
        step();
        key_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            exp_v = exp_key(c);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL key cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            step();
        end
        $display("key: single beep plus gap checked");
    endtask

    task automatic test_fail();
        fail_req = 1'b1;
        step();
        fail_req = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            exp_v = exp_fail(c);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL fail_pat cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            step();
        end
        $display("fail: double beep checked");
    endtask

    task automatic test_preempt();
        key_req = 1'b1;
        step();
        key_req = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            exp_v = (c <= 3) ? exp_key(c) : exp_fail(c - 3);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL preempt cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            if (c == 3) fail_req = 1'b1;
            step();
            fail_req = 1'b0;
        end
        $display("preempt: key aborted by fail");
    endtask

    task automatic test_pending();
        fail_req = 1'b1;
        step();
        fail_req = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            if (c <= 20)      exp_v = exp_fail(c);
            else if (c == 21) exp_v = exp_fail(21) | exp_key(1);
            else if (c <= 32) exp_v = exp_key(c - 20);
            else              exp_v = 7'b0;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL pending cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            if (c == 2 || c == 5) key_req = 1'b1;
            step();
            key_req = 1'b0;
        end
        $display("pending: collapsed key follows fail");
    endtask

    task automatic test_simultaneous();
        key_req  = 1'b1;
        pass_req = 1'b1;
        step();
        key_req  = 1'b0;
        pass_req = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            if (c <= 9)       exp_v = exp_pass(c);
            else if (c == 10) exp_v = exp_pass(10) | exp_key(1);
            else if (c <= 21) exp_v = exp_key(c - 9);
            else              exp_v = 7'b0;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL simultaneous cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            step();
        end
        $display("simultaneous: pass first, key pending");
    endtask

    task automatic test_alarm();
        alarm_en = 1'b1;
        step();
        for (int c = 1; c <= 17; c++) begin
            exp_v = exp_alarm(c, 2);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL alarm cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            if (c == 10) alarm_en = 1'b0;
            step();
        end
        $display("alarm: two beeps after mid-tone drop");
    endtask

    task automatic test_alarm_preempt();
        key_req = 1'b1;
        step();
        key_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 2)       exp_v = exp_key(c);
            else if (c <= 11) exp_v = exp_alarm(c - 2, 1);
            else              exp_v = 7'b0;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL alarm_preempt cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            alarm_en = (c == 2);
            step();
        end
        alarm_en = 1'b0;
        $display("alarm_preempt: key aborted, one alarm beep");
    endtask

    task automatic test_reset_mid();
        pass_req = 1'b1;
        step();
        pass_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            exp_v = exp_pass(c);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_pass cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            if (c == 2) key_req = 1'b1;
            if (c < 4) begin
                step();
                key_req = 1'b0;
            end
        end
        #1 RSTn = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", obs, 7'b0);
        end
        step();
        #2 RSTn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL reset_quiet cyc=%0d got=%b exp=%b", c, obs, 7'b0);
            end
        end
        key_req = 1'b1;
        step();
        key_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            exp_v = exp_key(c);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_key cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            step();
        end
        $display("reset_mid: abort, pending cleared, key replays");
    endtask

    initial begin
        test_reset();
        test_key();
        test_fail();
        test_preempt();
        test_pending();
        test_simultaneous();
        test_alarm();
        test_alarm_preempt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
